// File: rtl/usb4_tx_pkg.sv
// Shared definitions for the lane transmit training sequencer.
//   sel_e     : datapath select encoding driven on d_sel
//   state_e   : sequencer state; values match sel_e so d_sel is the state code
//   DEF_*     : default ordered-set counts and watchdog limit
package usb4_tx_pkg;

    typedef enum logic [3:0] {
        SEL_SLOS1  = 4'd0,
        SEL_SLOS2  = 4'd1,
        SEL_G3_TS1 = 4'd2,
        SEL_G3_TS2 = 4'd3,
        SEL_G4_TS1 = 4'd4,
        SEL_G4_TS2 = 4'd5,
        SEL_G4_TS3 = 4'd6,
        SEL_G4_TS4 = 4'd7,
        SEL_DATA   = 4'd8,
        SEL_IDLE   = 4'd9
    } sel_e;

    typedef enum logic [3:0] {
        ST_SLOS1  = 4'd0,
        ST_SLOS2  = 4'd1,
        ST_G3_TS1 = 4'd2,
        ST_G3_TS2 = 4'd3,
        ST_G4_TS1 = 4'd4,
        ST_G4_TS2 = 4'd5,
        ST_G4_TS3 = 4'd6,
        ST_G4_TS4 = 4'd7,
        ST_DATA   = 4'd8,
        ST_IDLE   = 4'd9
    } state_e;

    localparam int unsigned DEF_N_SLOS1  = 2;
    localparam int unsigned DEF_N_SLOS2  = 2;
    localparam int unsigned DEF_N_G3_TS1 = 16;
    localparam int unsigned DEF_N_G3_TS2 = 8;
    localparam int unsigned DEF_N_G4_TS1 = 4;
    localparam int unsigned DEF_N_G4_TS2 = 4;
    localparam int unsigned DEF_N_G4_TS3 = 4;
    localparam int unsigned DEF_N_G4_TS4 = 16;
    localparam int unsigned DEF_TIMEOUT  = 4096;

    function automatic sel_e state_sel(input state_e s);
        return sel_e'(4'(s));
    endfunction

    function automatic logic is_training(input state_e s);
        return (s != ST_IDLE) && (s != ST_DATA);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lane_tx_sequencer_if.sv
// Control/status bundle between the training FSM / datapath and the
// lane transmit sequencer.
//   start, gen4, stop : training requests from the logical layer
//   os_sent           : one-cycle "ordered set done" pulse from the datapath
//   d_sel             : datapath pattern select
//   busy, done, link_up, timeout_err : sequencer status
// master drives requests; slave is the sequencer.
interface lane_tx_sequencer_if;
    logic       start;
    logic       gen4;
    logic       stop;
    logic       os_sent;
    logic [3:0] d_sel;
    logic       busy;
    logic       done;
    logic       link_up;
    logic       timeout_err;

    modport master (
        output start, gen4, stop, os_sent,
        input  d_sel, busy, done, link_up, timeout_err
    );

    modport slave (
        input  start, gen4, stop, os_sent,
        output d_sel, busy, done, link_up, timeout_err
    );
endinterface

// File: rtl/phase_watchdog.sv
// Per-phase stall watchdog: counts enabled cycles, cleared on demand.
//   clk, rst : clock, synchronous active-high reset
//   clr      : zero the count (takes priority over en)
//   en       : count this cycle
//   expired  : count has reached TIMEOUT-1
module phase_watchdog #(
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == W'(TIMEOUT - 1));

    // Holding at the limit keeps the counter from wrapping if the owner
    // does not clear it on expiry.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lane_tx_sequencer.sv
// Lane transmit sequencer: walks the datapath through link-training
// ordered-set phases, counting os_sent pulses per phase, and aborts to
// idle if os_sent stalls longer than TIMEOUT cycles.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of lane_tx_sequencer_if (requests in, status out)
//
// state     | meaning
// ST_IDLE   | waiting for start
// ST_SLOS1  | Gen3 SLOS1 sets
// ST_SLOS2  | Gen3 SLOS2 sets
// ST_G3_TS1 | Gen3 TS1 sets
// ST_G3_TS2 | Gen3 TS2 sets
// ST_G4_TS1 | Gen4 TS1 sets
// ST_G4_TS2 | Gen4 TS2 sets
// ST_G4_TS3 | Gen4 TS3 sets
// ST_G4_TS4 | Gen4 TS4 sets
// ST_DATA   | link up, held until stop or rst
module lane_tx_sequencer
    import usb4_tx_pkg::*;
#(
    parameter int unsigned N_SLOS1  = DEF_N_SLOS1,
    parameter int unsigned N_SLOS2  = DEF_N_SLOS2,
    parameter int unsigned N_G3_TS1 = DEF_N_G3_TS1,
    parameter int unsigned N_G3_TS2 = DEF_N_G3_TS2,
    parameter int unsigned N_G4_TS1 = DEF_N_G4_TS1,
    parameter int unsigned N_G4_TS2 = DEF_N_G4_TS2,
    parameter int unsigned N_G4_TS3 = DEF_N_G4_TS3,
    parameter int unsigned N_G4_TS4 = DEF_N_G4_TS4,
    parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                 clk,
    input  logic                 rst,
    lane_tx_sequencer_if.slave   bus
);

    localparam int unsigned N_MAX = max_u(max_u(max_u(N_SLOS1, N_SLOS2), max_u(N_G3_TS1, N_G3_TS2)),
                                          max_u(max_u(N_G4_TS1, N_G4_TS2), max_u(N_G4_TS3, N_G4_TS4)));
    localparam int unsigned CW = $clog2(N_MAX) + 1;

    if (N_SLOS1 == 0 || N_SLOS2 == 0 || N_G3_TS1 == 0 || N_G3_TS2 == 0 ||
        N_G4_TS1 == 0 || N_G4_TS2 == 0 || N_G4_TS3 == 0 || N_G4_TS4 == 0 || TIMEOUT == 0) begin : g_bad_param
        $error("lane_tx_sequencer: ordered-set counts and TIMEOUT must be nonzero");
    end

    state_e        state_q, state_d;
    logic [CW-1:0] os_cnt_q, os_cnt_d;
    logic          first_q, first_d;
    logic [3:0]    d_sel_q, d_sel_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          link_up_q, link_up_d;
    logic          timeout_err_q, timeout_err_d;

    logic          counted;
    logic          wd_expired;
    logic [CW-1:0] cnt_last;
    state_e        phase_next;

    // Phase length and successor for the current phase.
    always_comb begin
        cnt_last   = '0;
        phase_next = ST_IDLE;
        case (state_q)
            ST_SLOS1:  begin cnt_last = CW'(N_SLOS1 - 1);  phase_next = ST_SLOS2;  end
            ST_SLOS2:  begin cnt_last = CW'(N_SLOS2 - 1);  phase_next = ST_G3_TS1; end
            ST_G3_TS1: begin cnt_last = CW'(N_G3_TS1 - 1); phase_next = ST_G3_TS2; end
            ST_G3_TS2: begin cnt_last = CW'(N_G3_TS2 - 1); phase_next = ST_DATA;   end
            ST_G4_TS1: begin cnt_last = CW'(N_G4_TS1 - 1); phase_next = ST_G4_TS2; end
            ST_G4_TS2: begin cnt_last = CW'(N_G4_TS2 - 1); phase_next = ST_G4_TS3; end
            ST_G4_TS3: begin cnt_last = CW'(N_G4_TS3 - 1); phase_next = ST_G4_TS4; end
            ST_G4_TS4: begin cnt_last = CW'(N_G4_TS4 - 1); phase_next = ST_DATA;   end
            default:   begin cnt_last = '0;                phase_next = ST_IDLE;   end
        endcase
    end

    always_comb begin
        state_d       = state_q;
        os_cnt_d      = os_cnt_q;
        timeout_err_d = timeout_err_q;
        // A pulse in the first cycle of a phase may belong to the previous
        // pattern, so it is not counted.
        counted       = bus.os_sent && !first_q && is_training(state_q);

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d       = bus.gen4 ? ST_G4_TS1 : ST_SLOS1;
                    timeout_err_d = 1'b0;
                end
            end
            ST_DATA: begin
                state_d = ST_DATA;
            end
            default: begin
                // A counted pulse beats a simultaneous watchdog expiry.
                if (counted) begin
                    if (os_cnt_q == cnt_last) begin
                        state_d  = phase_next;
                        os_cnt_d = '0;
                    end else begin
                        os_cnt_d = os_cnt_q + 1'b1;
                    end
                end else if (wd_expired) begin
                    state_d       = ST_IDLE;
                    os_cnt_d      = '0;
                    timeout_err_d = 1'b1;
                end
            end
        endcase

        if (bus.stop) begin
            state_d       = ST_IDLE;
            os_cnt_d      = '0;
            timeout_err_d = timeout_err_q;
        end

        first_d   = (state_d != state_q);
        d_sel_d   = 4'(state_sel(state_d));
        busy_d    = is_training(state_d);
        link_up_d = (state_d == ST_DATA);
        done_d    = (state_d == ST_DATA) && (state_q != ST_DATA);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            os_cnt_q      <= '0;
            first_q       <= 1'b0;
            d_sel_q       <= 4'(SEL_IDLE);
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            link_up_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            os_cnt_q      <= os_cnt_d;
            first_q       <= first_d;
            d_sel_q       <= d_sel_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            link_up_q     <= link_up_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    phase_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (counted || (state_d != state_q)),
        .en      (is_training(state_q)),
        .expired (wd_expired)
    );

    assign bus.d_sel       = d_sel_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.link_up     = link_up_q;
    assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_lane_tx_sequencer.sv
module tb_lane_tx_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    lane_tx_sequencer_if bus_if ();

    lane_tx_sequencer #(.TIMEOUT(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic       rst;
        logic       start;
        logic       gen4;
        logic       stop;
        logic       os;
        logic [3:0] e_sel;
        logic       e_busy;
        logic       e_done;
        logic       e_link;
        logic       e_terr;
    } vec_t;

    vec_t tbl [15];

    task automatic drive(input logic r, input logic s, input logic g, input logic sp, input logic os);
        rst            = r;
        bus_if.start   = s;
        bus_if.gen4    = g;
        bus_if.stop    = sp;
        bus_if.os_sent = os;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [3:0] es, input logic eb, input logic ed,
                         input logic el, input logic et);
        logic [7:0] got;
        logic [7:0] exp;
        got = {bus_if.d_sel, bus_if.busy, bus_if.done, bus_if.link_up, bus_if.timeout_err};
        exp = {es, eb, ed, el, et};
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got d_sel=%0d busy=%b done=%b link_up=%b timeout_err=%b, want d_sel=%0d busy=%b done=%b link_up=%b timeout_err=%b",
                     nm, got[7:4], got[3], got[2], got[1], got[0], es, eb, ed, el, et);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pulses(input int n, input int gap);
        repeat (n) begin
            idle(gap - 1);
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic full_run(input string nm, input logic g4, input int gap,
                            input int cnt [4], input logic [3:0] sel [5]);
        logic last;
        drive(1'b0, 1'b1, g4, 1'b0, 1'b0);
        check({nm, "_start"}, sel[0], 1'b1, 1'b0, 1'b0, 1'b0);
        for (int p = 0; p < 4; p++) begin
            last = (p == 3);
            pulses(cnt[p] - 1, gap);
            check($sformatf("%s_pre%0d", nm, p), sel[p], 1'b1, 1'b0, 1'b0, 1'b0);
            pulses(1, gap);
            check($sformatf("%s_adv%0d", nm, p), sel[p+1], !last, last, last, 1'b0);
        end
        idle(1);
        check({nm, "_data_hold"}, 4'd8, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, !g4, 1'b0, 1'b0);
        check({nm, "_start_in_data"}, 4'd8, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        int         c3 [4];
        int         c4 [4];
        logic [3:0] s3 [5];
        logic [3:0] s4 [5];

        c3 = '{2, 2, 16, 8};
        c4 = '{4, 4, 4, 16};
        s3 = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd8};
        s4 = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd8};

        //         rst start gen4 stop os   sel   busy done link terr
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};

        bus_if.start   = 1'b0;
        bus_if.gen4    = 1'b0;
        bus_if.stop    = 1'b0;
        bus_if.os_sent = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].rst, tbl[i].start, tbl[i].gen4, tbl[i].stop, tbl[i].os);
            check($sformatf("vec%0d", i), tbl[i].e_sel, tbl[i].e_busy, tbl[i].e_done,
                  tbl[i].e_link, tbl[i].e_terr);
        end

        // Gen3 full run, os_sent every 64 cycles (pulse lands as watchdog hits its limit).
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        full_run("gen3", 1'b0, 64, c3, s3);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("gen3_stop", 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);

        // Gen4 full run, os_sent every 32 cycles.
        full_run("gen4", 1'b1, 32, c4, s4);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("gen4_stop", 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);

        // Blanking at G3_TS1 entry.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        pulses(4, 4);
        check("blank_enter_ts1", 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        pulses(15, 3);
        check("blank_ts1_15", 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        pulses(1, 3);
        check("blank_ts1_16", 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);

        // stop together with the final G3_TS2 os_sent.
        pulses(7, 3);
        check("ts2_cnt7", 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check("stop_final_os", 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("restart_slos1", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        pulses(1, 3);
        check("restart_cnt1", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        pulses(1, 3);
        check("restart_cnt2", 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Watchdog expiry in G4_TS2.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        pulses(4, 3);
        check("to_ts2", 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        pulses(2, 3);
        idle(63);
        check("to_63", 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1);
        check("to_64", 4'd9, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(2);
        check("to_sticky", 4'd9, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("to_stop_keeps", 4'd9, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        check("to_stop_start", 4'd9, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("to_start_clears", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        // rst in the middle of G4_TS4.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        pulses(12, 2);
        check("rst_ts4", 4'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        pulses(5, 2);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_mid", 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        check("rst_after", 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        pulses(3, 2);
        check("rst_restart_3", 4'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        pulses(1, 2);
        check("rst_restart_4", 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
